// File: rtl/polyvec_pkg.sv
// polyvec_pkg: shared widths and reader state encoding for the polyvec RAM slice
package polyvec_pkg;
  localparam int ADDR_W = 8;
  localparam int DEPTH = 256;
  localparam int DATA_W = 12;
  localparam int LANES = 4;
  localparam int PACKED_W = LANES * DATA_W;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
endpackage

// File: rtl/polyvec_skid_fifo.sv
// polyvec_skid_fifo: 2-entry FIFO whose head register only changes on pop or a push into empty
module polyvec_skid_fifo import polyvec_pkg::*; #(
  parameter int width = PACKED_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] din,
  output logic [width-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);
  logic [width-1:0] head, tail;
  assign dout = head;
  assign full = count == 2'd2;
  assign empty = count == 2'd0;
  always_ff @(posedge clk)
    if (rst) begin
      count <= 2'd0;
      head <= '0;
      tail <= '0;
    end else begin
      count <= count + 2'(push) - 2'(pop);
      if (pop) head <= full ? tail : din;
      else if (push && empty) head <= din;
      if (push && (full || (count == 2'd1 && !pop))) tail <= din;
    end
endmodule

// File: rtl/polyvec_reader.sv
// polyvec_reader: walks len RAM words from start_addr and streams the 4 lanes as valid/ready beats
module polyvec_reader import polyvec_pkg::*; #(
  parameter int addr_width = ADDR_W,
  parameter int depth = DEPTH,
  parameter int data_width = DATA_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [addr_width-1:0]   start_addr,
  input  logic [addr_width:0]     len,
  output logic [addr_width-1:0]   ram_raddr,
  input  logic [data_width-1:0]   ram_dout0,
  input  logic [data_width-1:0]   ram_dout1,
  input  logic [data_width-1:0]   ram_dout2,
  input  logic [data_width-1:0]   ram_dout3,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [4*data_width-1:0] m_data,
  output logic                    m_last,
  output logic                    busy,
  output logic                    done
);
  localparam int pw = 4 * data_width;
  localparam logic [addr_width:0] max_len = (addr_width + 1)'(depth);
  logic [1:0] state;
  logic [addr_width-1:0] rd_ptr;
  logic [addr_width:0] remaining;
  logic [1:0] count;
  logic full, empty, pop, fetch;
  logic [pw:0] head;
  assign pop = m_valid & m_ready;
  assign fetch = state == RUN && remaining != '0 && (!full || pop);
  assign m_valid = !empty;
  assign {m_last, m_data} = head;
  assign ram_raddr = rd_ptr;
  assign busy = state == RUN;
  assign done = state == FLUSH;
  polyvec_skid_fifo #(.width(pw + 1)) fifo (
    .clk(clk),
    .rst(rst),
    .push(fetch),
    .pop(pop),
    .din({remaining == (addr_width + 1)'(1), ram_dout3, ram_dout2, ram_dout1, ram_dout0}),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  // Leave RUN only when nothing is left to fetch and this cycle's pop drains the FIFO
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      rd_ptr <= '0;
      remaining <= '0;
    end else if (state == IDLE && start) begin
      state <= len == '0 ? FLUSH : RUN;
      rd_ptr <= start_addr;
      remaining <= len > max_len ? max_len : len;
    end else if (state == RUN) begin
      if (fetch) begin
        rd_ptr <= rd_ptr + addr_width'(1);
        remaining <= remaining - (addr_width + 1)'(1);
      end
      if (remaining == '0 && count == 2'(pop)) state <= FLUSH;
    end else if (state == FLUSH) state <= IDLE;
endmodule

// File: tb/tb_polyvec_reader.sv
// tb_polyvec_reader: directed transfers checked against a scoreboard of expected beats
module tb_polyvec_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic m_ready = 1'b0;
  logic [7:0] start_addr = '0;
  logic [8:0] len = '0;
  logic [7:0] ram_raddr;
  logic [11:0] ram_dout0, ram_dout1, ram_dout2, ram_dout3;
  logic m_valid, m_last, busy, done;
  logic [47:0] m_data;
  logic [11:0] ram [4][256];
  logic [48:0] sb[$];
  logic [48:0] exp_beat;
  logic [47:0] hold_d;
  logic [7:0] sa;
  bit hold_v = 0;
  bit ahead_chk = 0;
  int checks = 0, errors = 0, cyc_n = 0;
  int beats, t_first, t_last, t_done, c0;

  always #5 clk = ~clk;

  assign ram_dout0 = ram[0][ram_raddr];
  assign ram_dout1 = ram[1][ram_raddr];
  assign ram_dout2 = ram[2][ram_raddr];
  assign ram_dout3 = ram[3][ram_raddr];

  polyvec_reader dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .start_addr(start_addr),
    .len(len),
    .ram_raddr(ram_raddr),
    .ram_dout0(ram_dout0),
    .ram_dout1(ram_dout1),
    .ram_dout2(ram_dout2),
    .ram_dout3(ram_dout3),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .m_last(m_last),
    .busy(busy),
    .done(done)
  );

  function automatic logic [47:0] word(input int a);
    logic [47:0] w;
    for (int k = 0; k < 4; k++) w[k*12 +: 12] = 12'((a * 4 + k) % 4096);
    return w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called mid-low-phase after inputs are set: observes this cycle, then advances one clock
  task automatic cyc();
    if (m_valid && t_first < 0) t_first = cyc_n;
    if (ahead_chk && busy) chk("ahead", 64'((8'(ram_raddr - sa) - beats) <= 2), 1);
    if (hold_v) chk("hold", {m_valid, m_data}, {1'b1, hold_d});
    hold_v = m_valid && !m_ready;
    hold_d = m_data;
    if (m_valid && m_ready) begin
      if (sb.size() == 0) chk("extra_beat", 64'(sb.size()), 1);
      else begin
        exp_beat = sb.pop_front();
        chk("beat", {m_last, m_data}, exp_beat);
      end
      if (m_last) t_last = cyc_n;
      beats++;
    end
    if (done && t_done < 0) t_done = cyc_n;
    @(posedge clk);
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic go(input int a, input int l);
    int n;
    n = l > 256 ? 256 : l;
    sa = 8'(a);
    start_addr = 8'(a);
    len = 9'(l);
    beats = 0;
    t_first = -1;
    t_last = -1;
    t_done = -1;
    for (int i = 0; i < n; i++) sb.push_back({i == n - 1, word((a + i) % 256)});
    c0 = cyc_n;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic finish_xfer(input int budget, input int mode);
    for (int i = 0; i < budget && t_done < 0; i++) begin
      m_ready = mode == 0 ? 1'b1 : (i % 3 == 0);
      cyc();
    end
    m_ready = 1'b1;
    chk("done_seen", 64'(t_done >= 0), 1);
    chk("sb_empty", 64'(sb.size()), 0);
  endtask

  initial begin
    for (int a = 0; a < 256; a++)
      for (int k = 0; k < 4; k++) ram[k][a] = 12'((a * 4 + k) % 4096);
    beats = 0; t_first = -1; t_last = -1; t_done = -1; c0 = 0; sa = '0;
    @(negedge clk);
    cyc();
    cyc();
    chk("reset_outs", {ram_raddr, m_valid, m_data, m_last, busy, done}, 0);
    rst = 1'b0;
    m_ready = 1'b1;
    cyc();
    // basic transfer and latency
    go(0, 4);
    chk("t1_busy", busy, 1);
    chk("t1_raddr", ram_raddr, 0);
    chk("t1_valid_n1", m_valid, 0);
    finish_xfer(20, 0);
    chk("t1_first", 64'(t_first - c0), 2);
    chk("t1_last", 64'(t_last - c0), 5);
    chk("t1_done", 64'(t_done - c0), 6);
    chk("t1_beats", 64'(beats), 4);
    chk("t1_done_pulse", {done, busy}, 0);
    // address wrap
    go(254, 4);
    finish_xfer(20, 0);
    chk("t2_beats", 64'(beats), 4);
    chk("t2_last", 64'(t_last - c0), 5);
    // back-pressure
    ahead_chk = 1;
    go(0, 16);
    finish_xfer(100, 1);
    ahead_chk = 0;
    chk("t3_beats", 64'(beats), 16);
    // zero length
    go(7, 0);
    finish_xfer(10, 0);
    chk("t4_done", 64'(t_done - c0), 1);
    chk("t4_novalid", 64'(t_first < 0), 1);
    chk("t4_beats", 64'(beats), 0);
    // clamp to depth
    go(10, 300);
    finish_xfer(400, 0);
    chk("t5_beats", 64'(beats), 256);
    chk("t5_done", 64'(t_done - c0), 258);
    // start while busy is ignored
    go(20, 10);
    cyc();
    cyc();
    start = 1'b1;
    start_addr = 8'd100;
    len = 9'd5;
    cyc();
    start = 1'b0;
    finish_xfer(40, 0);
    chk("t6_beats", 64'(beats), 10);
    cyc();
    cyc();
    chk("t6_idle", {m_valid, busy, done}, 0);
    // reset mid-transfer
    go(50, 10);
    for (int i = 0; i < 30 && beats < 5; i++) cyc();
    chk("t7_beats_pre", 64'(beats), 5);
    rst = 1'b1;
    m_ready = 1'b0;
    cyc();
    rst = 1'b0;
    hold_v = 0;
    chk("t7_outs", {ram_raddr, m_valid, m_data, m_last, busy, done}, 0);
    cyc();
    chk("t7_nodone", {done, busy, m_valid}, 0);
    sb.delete();
    m_ready = 1'b1;
    go(5, 3);
    finish_xfer(20, 0);
    chk("t7_fresh_beats", 64'(beats), 3);
    chk("t7_fresh_done", 64'(t_done - c0), 5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/polyvec_reader.md
Name: polyvec_reader

Overview:
- Read-side streaming engine for the 4-bank polyvec RAM (one shared read address, combinational read, 4 lanes).
- On `start`, it walks `len` consecutive addresses from `start_addr`, wrapping mod `depth`.
- Each address's 4 coefficients are packed into one beat on a valid/ready stream toward the bus/CPU interface.
- A 2-entry buffer absorbs back-pressure, giving 1 beat/cycle throughput while `m_ready` is high.

Parameters:
- addr_width, 8, RAM address width
- depth, 256, RAM depth in words; power of two, equal to 2^addr_width
- data_width, 12, coefficient width per bank

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- start_addr  in  addr_width  first RAM address to read
- len  in  addr_width+1  number of words to read; 0..depth
- ram_raddr  out  addr_width  read address to RAM raddr
- ram_dout0..ram_dout3  in  data_width each  RAM bank outputs, valid in the same cycle as ram_raddr
- m_valid  out  1  stream beat valid
- m_ready  in  1  downstream accept
- m_data  out  4*data_width  {dout3,dout2,dout1,dout0}
- m_last  out  1  marks the final beat of the transfer
- busy  out  1  high from the cycle after start until the done pulse
- done  out  1  one-cycle pulse after the final handshake

Behaviour:
- Clock and reset: one clock `clk`; `rst` is synchronous, active-high.
- Reset values: state IDLE, FIFO empty, rd_ptr=0, remaining=0. All outputs are 0: ram_raddr, m_valid, m_data, m_last, busy, done.
- State IDLE:
  - start=1 and len=0: go to FLUSH; done pulses in the next cycle; no beats are issued.
  - start=1 and len>0: latch rd_ptr=start_addr and remaining=min(len,depth); go to RUN.
- State RUN:
  - ram_raddr=rd_ptr (registered).
  - pop = m_valid & m_ready.
  - fetch = (remaining>0) & (fifo_count<2 | pop).
  - On fetch: push {ram_dout3..0} with a last flag (remaining==1); rd_ptr=rd_ptr+1 mod depth; remaining-=1.
  - When remaining==0 and the FIFO is empty after the current pop, go to FLUSH.
- State FLUSH: done=1 for exactly one cycle, busy=0, return to IDLE.
- Stream rules:
  - m_valid = FIFO non-empty; m_data and m_last come from the FIFO head.
  - Once asserted, m_valid and m_data must hold stable until accepted.
  - Push and pop in the same cycle are both legal, including when the FIFO is full.
- Latency: start sampled at edge N → ram_raddr=start_addr during cycle N+1 → m_valid first high in cycle N+2. With m_ready held high, beats arrive back-to-back; the last beat is in cycle N+1+len and done is in cycle N+2+len.
- Boundaries:
  - Address wrap: 255→0 at default depth.
  - len=depth reads every word exactly once.
  - len>depth is clamped to depth.
  - start while busy is ignored.
  - m_ready low: fetch stops once the FIFO holds 2 entries; rd_ptr freezes; no word is dropped or duplicated.
- Reset mid-transfer: the next cycle is IDLE with the FIFO flushed and all outputs 0. No done pulse is issued.
- RAM writes to addresses already fetched are not reflected in the stream; writes to addresses not yet fetched are.

Decomposition:
- Shared package `polyvec_pkg`:
  - ADDR_W=8, DEPTH=256, DATA_W=12, LANES=4
  - PACKED_W=LANES*DATA_W
  - reader state encoding: IDLE/RUN/FLUSH
- Sub-module `polyvec_skid_fifo`: 2-entry, width PACKED_W+1 (data + last); push/pop/full/empty/count; synchronous reset.

Test Plan:
- Preload bank k[a] = (a*4+k) mod 4096; start_addr=0, len=4, m_ready=1 → beats {3,2,1,0}, {7,6,5,4}, {11,10,9,8}, {15,14,13,12} on consecutive cycles starting N+2; m_last only on the 4th beat; done at N+6.
- start_addr=254, len=4 → beats read addresses 254, 255, 0, 1 in order; m_last on address 1.
- len=16 with m_ready toggling 1,0,0,1,… → exactly 16 beats in address order. At most 2 fetches occur ahead of acceptance. m_data is held stable while m_valid=1 and m_ready=0.
- len=0 → no m_valid at any time; done pulses one cycle after start. Also: len=300 → exactly 256 beats.
- Assert start again during RUN → ignored, transfer count unchanged. Assert rst at beat 5 of 10 → next cycle all outputs 0, no done; a fresh start then operates normally.
